// File: rtl/intra_pred_buf.sv
// intra_pred_buf
//   Captures 4x4 predicted blocks from the intra prediction sequencer (any
//   X/Y order within a TU), holds each TU in one half of a ping-pong buffer,
//   and replays it in forward raster order over a valid/ready stream.
//
//   state (read FSM) | meaning
//   -----------------+-------------------------------------------------------
//   RD_IDLE          | waiting for bank[rb] to become FULL
//   RD_DRAIN         | issuing one read per cycle while the skid FIFO has room
//   RD_WAIT          | all reads issued; waiting for the last beat to leave
//
// Ports
//   clk, arst_n, rst_n          clock, async / sync active-low resets
//   in_valid, in_data, X, Y     predicted block and its position in the TU
//   order, tuSize, cIdx         sequencer order code (7 = last), TU size, comp.
//   bStop                       stall to sequencer (write bank not free)
//   out_valid, out_ready        output handshake
//   out_data, out_x, out_y      block and position, raster order
//   out_cIdx, out_last          component of the TU, final beat marker
module intra_pred_buf #(
    parameter int BIT_DEPTH = 8,
    parameter int BLK_W     = 16*BIT_DEPTH
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [BLK_W-1:0] in_data,
    input  logic [2:0]       X,
    input  logic [2:0]       Y,
    input  logic [2:0]       order,
    input  logic [2:0]       tuSize,
    input  logic [1:0]       cIdx,
    output logic             bStop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic [2:0]       out_x,
    output logic [2:0]       out_y,
    output logic [1:0]       out_cIdx,
    output logic             out_last
);

    typedef enum logic [1:0] {BK_EMPTY, BK_FILLING, BK_FULL, BK_DRAINING} bank_st_e;
    typedef enum logic [1:0] {RD_IDLE, RD_DRAIN, RD_WAIT} rd_st_e;

    typedef struct packed {
        logic [BLK_W-1:0] data;
        logic [2:0]       x;
        logic [2:0]       y;
        logic [1:0]       cidx;
        logic             last;
    } ent_t;

    logic [BLK_W-1:0] mem_q [128];

    bank_st_e   bank_q      [2];
    logic [2:0] meta_size_q [2];
    logic [1:0] meta_cidx_q [2];
    logic       wb_q;
    logic       rb_q;

    rd_st_e     rd_st_q;
    logic [2:0] rx_q;
    logic [2:0] ry_q;
    logic [2:0] lim_q;

    // Read pipeline stage: memory output plus its tags
    logic [BLK_W-1:0] rd_data_q;
    logic             rd_vld_q;
    logic [2:0]       rd_x_q;
    logic [2:0]       rd_y_q;
    logic [1:0]       rd_cidx_q;
    logic             rd_last_q;
    ent_t             rd_ent;

    // Skid FIFO: head drives the outputs, s1 catches the beat in flight on a stall
    ent_t head_q;
    logic head_vld_q;
    ent_t s1_q;
    logic s1_vld_q;

    logic       wr_en;
    logic       tu_end;
    logic       pop;
    logic       issue;
    logic [2:0] occ;

    // Highest block index per side for each TU size; unknown codes act as 4x4
    function automatic logic [2:0] side_lim(input logic [2:0] ts);
        case (ts)
            3'd3:    return 3'd1;
            3'd4:    return 3'd3;
            3'd5:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    always_comb begin
        bStop  = (bank_q[wb_q] == BK_FULL) || (bank_q[wb_q] == BK_DRAINING);
        wr_en  = in_valid && !bStop;
        tu_end = (order == 3'd7) || (tuSize == 3'd2);
        pop    = head_vld_q && out_ready;
        // Beats held or in flight, less the one leaving this cycle, must leave room
        occ    = {2'b00, head_vld_q} + {2'b00, s1_vld_q} + {2'b00, rd_vld_q};
        issue  = (rd_st_q == RD_DRAIN) && ((occ - {2'b00, pop}) < 3'd2);
        rd_ent = '{data: rd_data_q, x: rd_x_q, y: rd_y_q, cidx: rd_cidx_q, last: rd_last_q};
    end

    assign out_valid = head_vld_q;
    assign out_data  = head_q.data;
    assign out_x     = head_q.x;
    assign out_y     = head_q.y;
    assign out_cIdx  = head_q.cidx;
    assign out_last  = head_q.last;

    // Storage has no reset: bank state alone decides what is valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wb_q, Y, X}] <= in_data;
        end
        if (issue) begin
            rd_data_q <= mem_q[{rb_q, ry_q, rx_q}];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bank_q[0]      <= BK_EMPTY;
            bank_q[1]      <= BK_EMPTY;
            meta_size_q[0] <= 3'd0;
            meta_size_q[1] <= 3'd0;
            meta_cidx_q[0] <= 2'd0;
            meta_cidx_q[1] <= 2'd0;
            wb_q           <= 1'b0;
            rb_q           <= 1'b0;
            rd_st_q        <= RD_IDLE;
            rx_q           <= 3'd0;
            ry_q           <= 3'd0;
            lim_q          <= 3'd0;
            rd_vld_q       <= 1'b0;
            rd_x_q         <= 3'd0;
            rd_y_q         <= 3'd0;
            rd_cidx_q      <= 2'd0;
            rd_last_q      <= 1'b0;
            head_q         <= '0;
            head_vld_q     <= 1'b0;
            s1_q           <= '0;
            s1_vld_q       <= 1'b0;
        end else if (!rst_n) begin
            bank_q[0]      <= BK_EMPTY;
            bank_q[1]      <= BK_EMPTY;
            meta_size_q[0] <= 3'd0;
            meta_size_q[1] <= 3'd0;
            meta_cidx_q[0] <= 2'd0;
            meta_cidx_q[1] <= 2'd0;
            wb_q           <= 1'b0;
            rb_q           <= 1'b0;
            rd_st_q        <= RD_IDLE;
            rx_q           <= 3'd0;
            ry_q           <= 3'd0;
            lim_q          <= 3'd0;
            rd_vld_q       <= 1'b0;
            rd_x_q         <= 3'd0;
            rd_y_q         <= 3'd0;
            rd_cidx_q      <= 2'd0;
            rd_last_q      <= 1'b0;
            head_q         <= '0;
            head_vld_q     <= 1'b0;
            s1_q           <= '0;
            s1_vld_q       <= 1'b0;
        end else begin
            // Write side only ever touches an EMPTY/FILLING bank, read side only
            // a FULL/DRAINING one, so the two updates below never collide.
            if (wr_en) begin
                if (tu_end) begin
                    bank_q[wb_q]      <= BK_FULL;
                    meta_size_q[wb_q] <= tuSize;
                    meta_cidx_q[wb_q] <= cIdx;
                    wb_q              <= ~wb_q;
                end else begin
                    bank_q[wb_q] <= BK_FILLING;
                end
            end

            case (rd_st_q)
                RD_IDLE: begin
                    if (bank_q[rb_q] == BK_FULL) begin
                        bank_q[rb_q] <= BK_DRAINING;
                        rx_q         <= 3'd0;
                        ry_q         <= 3'd0;
                        lim_q        <= side_lim(meta_size_q[rb_q]);
                        rd_st_q      <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (issue) begin
                        if (rx_q == lim_q) begin
                            rx_q <= 3'd0;
                            if (ry_q == lim_q) begin
                                rd_st_q <= RD_WAIT;
                            end else begin
                                ry_q <= ry_q + 3'd1;
                            end
                        end else begin
                            rx_q <= rx_q + 3'd1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (pop && head_q.last) begin
                        bank_q[rb_q] <= BK_EMPTY;
                        rb_q         <= ~rb_q;
                        rd_st_q      <= RD_IDLE;
                    end
                end
                default: rd_st_q <= RD_IDLE;
            endcase

            rd_vld_q <= issue;
            if (issue) begin
                rd_x_q    <= rx_q;
                rd_y_q    <= ry_q;
                rd_cidx_q <= meta_cidx_q[rb_q];
                rd_last_q <= (rx_q == lim_q) && (ry_q == lim_q);
            end

            // Skid FIFO; a push into a full FIFO cannot occur because issue
            // reserves a slot for every read in flight.
            if (pop) begin
                if (s1_vld_q) begin
                    head_q   <= s1_q;
                    s1_vld_q <= rd_vld_q;
                    if (rd_vld_q) begin
                        s1_q <= rd_ent;
                    end
                end else if (rd_vld_q) begin
                    head_q <= rd_ent;
                end else begin
                    head_vld_q <= 1'b0;
                end
            end else if (rd_vld_q) begin
                if (!head_vld_q) begin
                    head_q     <= rd_ent;
                    head_vld_q <= 1'b1;
                end else begin
                    s1_q     <= rd_ent;
                    s1_vld_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_intra_pred_buf.sv
module tb_intra_pred_buf;
    localparam int BIT_DEPTH = 8;
    localparam int BLK_W     = 16*BIT_DEPTH;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic [BLK_W-1:0] in_data = '0;
    logic [2:0]       X = 3'd0;
    logic [2:0]       Y = 3'd0;
    logic [2:0]       order = 3'd0;
    logic [2:0]       tuSize = 3'd2;
    logic [1:0]       cIdx = 2'd0;
    logic             bStop;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [BLK_W-1:0] out_data;
    logic [2:0]       out_x;
    logic [2:0]       out_y;
    logic [1:0]       out_cIdx;
    logic             out_last;

    always #5 clk = ~clk;

    intra_pred_buf #(.BIT_DEPTH(BIT_DEPTH), .BLK_W(BLK_W)) dut (
        .clk(clk), .arst_n(arst_n), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .X(X), .Y(Y),
        .order(order), .tuSize(tuSize), .cIdx(cIdx), .bStop(bStop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .out_cIdx(out_cIdx), .out_last(out_last)
    );

    // Reference model: each finished TU becomes a list of raster-order beats;
    // 'pending' counts finished TUs whose last beat has not been accepted.
    typedef struct packed {
        logic [BLK_W-1:0] data;
        logic [2:0]       x;
        logic [2:0]       y;
        logic [1:0]       c;
        logic             last;
    } beat_t;

    beat_t            exp_q[$];
    logic [BLK_W-1:0] tu_blk [64];
    int               pending = 0;
    int               vec_cnt = 0;
    int               err_cnt = 0;

    function automatic logic [BLK_W-1:0] rand_blk();
        logic [BLK_W-1:0] b;
        for (int i = 0; i < BLK_W/32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic void model_write(logic [BLK_W-1:0] d, int x, int y, int o, int t, int c);
        int    n;
        beat_t b;
        tu_blk[y*8+x] = d;
        if (o == 7 || t == 2) begin
            n = 1 << (t-2);
            for (int r = 0; r < n; r++) begin
                for (int cc = 0; cc < n; cc++) begin
                    b.data = tu_blk[r*8+cc];
                    b.x    = 3'(cc);
                    b.y    = 3'(r);
                    b.c    = 2'(c);
                    b.last = (r == n-1) && (cc == n-1);
                    exp_q.push_back(b);
                end
            end
            pending++;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        pending = 0;
    endfunction

    // Advance one clock: called at a negedge, returns at the next negedge
    task automatic tick();
        bit               acc_w, acc_r;
        logic [BLK_W-1:0] d;
        int               x, y, o, t, c;
        beat_t            b;
        acc_w = in_valid && (pending != 2) && arst_n && rst_n;
        acc_r = out_valid && out_ready && arst_n && rst_n;
        d = in_data; x = int'(X); y = int'(Y); o = int'(order); t = int'(tuSize); c = int'(cIdx);
        @(posedge clk);
        if (acc_w) model_write(d, x, y, o, t, c);
        if (acc_r && exp_q.size() != 0) begin
            b = exp_q.pop_front();
            if (b.last) pending--;
        end
        if (!rst_n || !arst_n) model_reset();
        @(negedge clk);
    endtask

    task automatic put(input logic [BLK_W-1:0] d, input int x, input int y, input int o,
                       input int t, input int c);
        in_valid = 1'b1; in_data = d; X = 3'(x); Y = 3'(y);
        order = 3'(o); tuSize = 3'(t); cIdx = 2'(c);
        tick();
    endtask

    // Whole TU in reverse raster order, order code 7 on the final block
    task automatic put_tu(input int t, input int c);
        int n;
        n = 1 << (t-2);
        for (int y = n-1; y >= 0; y--)
            for (int x = n-1; x >= 0; x--)
                put(rand_blk(), x, y, (x == 0 && y == 0) ? 7 : int'($urandom_range(0, 6)), t, c);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({out_valid, out_last, bStop, out_x, out_y, out_cIdx} !== 12'd0) begin
            err_cnt++;
            $display("FAIL reset_ctl: got v=%b l=%b stop=%b x=%0d y=%0d c=%0d, want all 0",
                     out_valid, out_last, bStop, out_x, out_y, out_cIdx);
        end
        vec_cnt++;
        if (out_data !== '0) begin
            err_cnt++; $display("FAIL reset_data: got %h, want 0", out_data);
        end
        arst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_8x8();
        int xs[4], ys[4], os[4];
        int lat, beats;
        xs = '{1, 0, 1, 0}; ys = '{1, 1, 0, 0}; os = '{0, 1, 2, 7};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) put(rand_blk(), xs[i], ys[i], os[i], 3, 0);
        in_valid = 1'b0;
        lat = -1; beats = 0;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            vec_cnt++;
            if (bStop !== (pending == 2)) begin
                err_cnt++; $display("FAIL 8x8_bstop: got %b, want %b", bStop, pending == 2);
            end
            if (out_valid) begin
                if (lat < 0) lat = k;
                beats++;
                vec_cnt++;
                if ({out_data, out_x, out_y, out_cIdx, out_last} !== exp_q[0]) begin
                    err_cnt++;
                    $display("FAIL 8x8_beat: got x=%0d y=%0d c=%0d last=%0d d=%h, want x=%0d y=%0d c=%0d last=%0d d=%h",
                             out_x, out_y, out_cIdx, out_last, out_data,
                             exp_q[0].x, exp_q[0].y, exp_q[0].c, exp_q[0].last, exp_q[0].data);
                end
            end
            tick();
        end
        vec_cnt++;
        if (lat != 3) begin
            err_cnt++; $display("FAIL 8x8_latency: got %0d cycles, want 3", lat);
        end
        vec_cnt++;
        if (beats != 4 || exp_q.size() != 0) begin
            err_cnt++; $display("FAIL 8x8_count: got %0d beats (%0d left), want 4 (0 left)", beats, exp_q.size());
        end
    endtask

    task automatic test_32x32();
        int first, run;
        bit gap;
        out_ready = 1'b1;
        for (int y = 7; y >= 0; y--) begin
            for (int x = 7; x >= 0; x--) begin
                vec_cnt++;
                if (bStop !== 1'b0) begin
                    err_cnt++; $display("FAIL 32x32_wr_bstop: got %b at (%0d,%0d), want 0", bStop, x, y);
                end
                put(rand_blk(), x, y, (x == 0 && y == 0) ? 7 : int'($urandom_range(0, 6)), 5, 0);
            end
        end
        in_valid = 1'b0;
        first = -1; run = 0; gap = 1'b0;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            vec_cnt++;
            if (bStop !== 1'b0) begin
                err_cnt++; $display("FAIL 32x32_rd_bstop: got %b, want 0", bStop);
            end
            if (out_valid) begin
                if (first < 0) first = k;
                run++;
                vec_cnt++;
                if ({out_data, out_x, out_y, out_cIdx, out_last} !== exp_q[0]) begin
                    err_cnt++;
                    $display("FAIL 32x32_beat: got x=%0d y=%0d last=%0d d=%h, want x=%0d y=%0d last=%0d d=%h",
                             out_x, out_y, out_last, out_data,
                             exp_q[0].x, exp_q[0].y, exp_q[0].last, exp_q[0].data);
                end
            end else if (first >= 0) begin
                gap = 1'b1;
            end
            tick();
        end
        vec_cnt++;
        if (run != 64 || gap || exp_q.size() != 0) begin
            err_cnt++; $display("FAIL 32x32_stream: got %0d beats gap=%0d left=%0d, want 64 gap=0 left=0",
                                run, gap, exp_q.size());
        end
    endtask

    task automatic test_two_16x16();
        int beats;
        out_ready = 1'b0;
        put_tu(4, 0);
        for (int y = 3; y >= 0; y--) begin
            for (int x = 3; x >= 0; x--) begin
                vec_cnt++;
                if (bStop !== 1'b0) begin
                    err_cnt++; $display("FAIL two16_wr_bstop: got %b at (%0d,%0d), want 0", bStop, x, y);
                end
                put(rand_blk(), x, y, (x == 0 && y == 0) ? 7 : int'($urandom_range(0, 6)), 4, 0);
            end
        end
        in_valid = 1'b0;
        vec_cnt++;
        if (bStop !== 1'b1) begin
            err_cnt++; $display("FAIL two16_rise: got %b, want 1", bStop);
        end
        for (int i = 0; i < 3; i++) begin
            put(rand_blk(), 0, 0, 7, 2, 3);
            vec_cnt++;
            if (bStop !== 1'b1) begin
                err_cnt++; $display("FAIL two16_hold: got %b, want 1", bStop);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        beats = 0;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            vec_cnt++;
            if (bStop !== (pending == 2)) begin
                err_cnt++; $display("FAIL two16_bstop: got %b, want %b", bStop, pending == 2);
            end
            if (out_valid) begin
                beats++;
                vec_cnt++;
                if ({out_data, out_x, out_y, out_cIdx, out_last} !== exp_q[0]) begin
                    err_cnt++;
                    $display("FAIL two16_beat: got x=%0d y=%0d c=%0d last=%0d d=%h, want x=%0d y=%0d c=%0d last=%0d d=%h",
                             out_x, out_y, out_cIdx, out_last, out_data,
                             exp_q[0].x, exp_q[0].y, exp_q[0].c, exp_q[0].last, exp_q[0].data);
                end
            end
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            vec_cnt++;
            if (out_valid !== 1'b0 || bStop !== 1'b0) begin
                err_cnt++; $display("FAIL two16_idle: got v=%b stop=%b, want 0 0", out_valid, bStop);
            end
            tick();
        end
        vec_cnt++;
        if (beats != 32 || exp_q.size() != 0) begin
            err_cnt++; $display("FAIL two16_count: got %0d beats (%0d left), want 32 (0 left)", beats, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit               pat[4];
        bit               stalled;
        logic [BLK_W-1:0] held;
        logic [5:0]       held_xy;
        int               acc;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b0;
        put_tu(4, 1);
        stalled = 1'b0; held = '0; held_xy = '0; acc = 0;
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
            out_ready = pat[k % 4];
            vec_cnt++;
            if (bStop !== (pending == 2)) begin
                err_cnt++; $display("FAIL bp_bstop: got %b, want %b", bStop, pending == 2);
            end
            if (stalled) begin
                vec_cnt++;
                if (out_valid !== 1'b1 || out_data !== held || {out_x, out_y} !== held_xy) begin
                    err_cnt++; $display("FAIL bp_hold: got v=%b d=%h, want v=1 d=%h", out_valid, out_data, held);
                end
            end
            if (out_valid) begin
                vec_cnt++;
                if ({out_data, out_x, out_y, out_cIdx, out_last} !== exp_q[0]) begin
                    err_cnt++;
                    $display("FAIL bp_beat: got x=%0d y=%0d c=%0d last=%0d d=%h, want x=%0d y=%0d c=%0d last=%0d d=%h",
                             out_x, out_y, out_cIdx, out_last, out_data,
                             exp_q[0].x, exp_q[0].y, exp_q[0].c, exp_q[0].last, exp_q[0].data);
                end
                if (out_ready) acc++;
            end
            stalled = out_valid && !out_ready;
            held = out_data; held_xy = {out_x, out_y};
            tick();
        end
        vec_cnt++;
        if (acc != 16 || exp_q.size() != 0) begin
            err_cnt++; $display("FAIL bp_count: got %0d accepted (%0d left), want 16 (0 left)", acc, exp_q.size());
        end
    endtask

    task automatic test_chroma();
        int beats;
        out_ready = 1'b1;
        put(rand_blk(), 0, 0, int'($urandom_range(0, 6)), 2, 1);
        put(rand_blk(), 0, 0, int'($urandom_range(0, 6)), 2, 2);
        in_valid = 1'b0;
        beats = 0;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            vec_cnt++;
            if (bStop !== (pending == 2)) begin
                err_cnt++; $display("FAIL chroma_bstop: got %b, want %b", bStop, pending == 2);
            end
            if (out_valid) begin
                beats++;
                vec_cnt++;
                if ({out_data, out_x, out_y, out_cIdx, out_last} !== exp_q[0]) begin
                    err_cnt++;
                    $display("FAIL chroma_beat: got c=%0d last=%0d d=%h, want c=%0d last=%0d d=%h",
                             out_cIdx, out_last, out_data, exp_q[0].c, exp_q[0].last, exp_q[0].data);
                end
            end
            tick();
        end
        vec_cnt++;
        if (beats != 2 || exp_q.size() != 0) begin
            err_cnt++; $display("FAIL chroma_count: got %0d beats (%0d left), want 2 (0 left)", beats, exp_q.size());
        end
    endtask

    task automatic test_arst_mid();
        int beats;
        out_ready = 1'b1;
        put_tu(4, 0);
        put(rand_blk(), 0, 0, 7, 2, 1);
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) begin
                vec_cnt++;
                if ({out_data, out_x, out_y, out_cIdx, out_last} !== exp_q[0]) begin
                    err_cnt++; $display("FAIL arst_pre_beat: got x=%0d y=%0d d=%h, want x=%0d y=%0d d=%h",
                                        out_x, out_y, out_data, exp_q[0].x, exp_q[0].y, exp_q[0].data);
                end
            end
            tick();
        end
        vec_cnt++;
        if (bStop !== 1'b1) begin
            err_cnt++; $display("FAIL arst_pre_bstop: got %b, want 1", bStop);
        end
        #1 arst_n = 1'b0;
        #1;
        vec_cnt++;
        if (out_valid !== 1'b0 || bStop !== 1'b0) begin
            err_cnt++; $display("FAIL arst_now: got v=%b stop=%b, want 0 0", out_valid, bStop);
        end
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        put_tu(3, 2);
        beats = 0;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            vec_cnt++;
            if (bStop !== (pending == 2)) begin
                err_cnt++; $display("FAIL arst_post_bstop: got %b, want %b", bStop, pending == 2);
            end
            if (out_valid) begin
                beats++;
                vec_cnt++;
                if ({out_data, out_x, out_y, out_cIdx, out_last} !== exp_q[0]) begin
                    err_cnt++;
                    $display("FAIL arst_post_beat: got x=%0d y=%0d c=%0d last=%0d d=%h, want x=%0d y=%0d c=%0d last=%0d d=%h",
                             out_x, out_y, out_cIdx, out_last, out_data,
                             exp_q[0].x, exp_q[0].y, exp_q[0].c, exp_q[0].last, exp_q[0].data);
                end
            end
            tick();
        end
        vec_cnt++;
        if (beats != 4 || exp_q.size() != 0) begin
            err_cnt++; $display("FAIL arst_post_count: got %0d beats (%0d left), want 4 (0 left)", beats, exp_q.size());
        end
    endtask

    task automatic test_soft_reset();
        int beats;
        out_ready = 1'b1;
        put_tu(3, 1);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vec_cnt++;
        if (out_valid !== 1'b0 || bStop !== 1'b0 || out_data !== '0) begin
            err_cnt++; $display("FAIL srst_state: got v=%b stop=%b d=%h, want 0 0 0", out_valid, bStop, out_data);
        end
        repeat (4) begin
            vec_cnt++;
            if (out_valid !== 1'b0) begin
                err_cnt++; $display("FAIL srst_flush: got v=%b, want 0", out_valid);
            end
            tick();
        end
        put(rand_blk(), 0, 0, 7, 2, 2);
        in_valid = 1'b0;
        beats = 0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            if (out_valid) begin
                beats++;
                vec_cnt++;
                if ({out_data, out_x, out_y, out_cIdx, out_last} !== exp_q[0]) begin
                    err_cnt++; $display("FAIL srst_beat: got c=%0d last=%0d d=%h, want c=%0d last=%0d d=%h",
                                        out_cIdx, out_last, out_data, exp_q[0].c, exp_q[0].last, exp_q[0].data);
                end
            end
            tick();
        end
        vec_cnt++;
        if (beats != 1 || exp_q.size() != 0) begin
            err_cnt++; $display("FAIL srst_count: got %0d beats (%0d left), want 1 (0 left)", beats, exp_q.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_8x8();
        test_32x32();
        test_two_16x16();
        test_backpressure();
        test_chroma();
        test_arst_mid();
        test_soft_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/intra_pred_buf.md
Name: intra_pred_buf

Overview:
- Downstream of the intra prediction sequencer; captures the 4x4 predicted sample blocks it emits, one per cycle, in the sequencer's reverse-raster X/Y order.
- Stores each block in a ping-pong TU buffer and replays the TU in forward raster order to the reconstruction stage over a valid/ready interface.
- Drives bStop back to the sequencer when no bank is free.

Parameters:
- BIT_DEPTH, 8, bits per sample.
- BLK_W, 16*BIT_DEPTH, width of one 4x4 block; sample (r,c) sits at bit offset (4r+c)*BIT_DEPTH.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- rst_n  in  1  synchronous active-low soft reset; same effect as arst_n
- in_valid  in  1  in_data holds a predicted block this cycle
- in_data  in  BLK_W  predicted 4x4 block
- X  in  3  block column within TU
- Y  in  3  block row within TU
- order  in  3  sequencer order code; 7 = last block of TU
- tuSize  in  3  2=4x4, 3=8x8, 4=16x16, 5=32x32
- cIdx  in  2  colour component
- bStop  out  1  stall to sequencer
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- out_data  out  BLK_W  block in raster order
- out_x  out  3  block column
- out_y  out  3  block row
- out_cIdx  out  2  component of the TU being drained
- out_last  out  1  final block of the TU

Behaviour:
- Reset (arst_n low, or rst_n low at clk edge):
  - out_valid=0, out_data=0, out_x=0, out_y=0, out_cIdx=0, out_last=0, bStop=0.
  - Both banks EMPTY; write-bank and read-bank pointers = 0.
  - Skid buffer emptied.
  - Reset mid-TU discards all buffered data.
- Storage:
  - 2 banks x 64 entries x BLK_W.
  - Address = {Y,X}.
  - Synchronous read with 1-cycle latency.
- Write:
  - A write occurs when in_valid && !bStop: in_data is written to bank[wb] at {Y,X}, and that bank becomes FILLING.
  - tu_end = (order==7) || (tuSize==2).
  - On a write with tu_end: latch tuSize and cIdx into the bank's metadata, set the bank FULL, toggle wb.
  - in_valid while bStop=1 is ignored; the sequencer holds its state.
- bStop:
  - bStop = (bank[wb] is FULL or DRAINING).
  - Registered-state derived, no combinational path from out_ready.
  - A bank freed at edge n is writable from cycle n+1.
- Read FSM, per rb:
  - IDLE: when bank[rb] is FULL, go to DRAIN and reset the counters.
  - DRAIN: issue a read each cycle while the skid buffer has room.
    - N = 1<<(tuSize-2) blocks per side.
    - Counters rx, ry step rx 0..N-1, then ry++.
    - The issue at rx=ry=N-1 is tagged last.
    - After the last issue, go to WAIT.
  - WAIT: when the last beat is accepted (out_valid && out_ready && out_last), set bank[rb] EMPTY, toggle rb, go to IDLE.
- Output:
  - 2-entry skid FIFO sustains 1 block/cycle while out_ready=1.
  - Issue is allowed only when occupancy + in-flight read < 2.
  - out_* hold stable while out_valid && !out_ready.
  - out_cIdx comes from the bank metadata.
- Overlap:
  - The sequencer may fill bank[wb] while bank[rb] drains.
  - Write and read in the same cycle to different banks are independent.
  - Write and read can never target the same bank in one cycle.
- Latency: first out_valid appears 3 cycles after the tu_end write (FULL seen, read issued, data registered).
- 4x4 TU: a single block, FULL after one write, out_last=1 on its only beat.

Test Plan:
- 8x8 TU (tuSize=3): writes (1,1),(0,1),(1,0),(0,0) with order 0,1,2,7, out_ready=1 -> out beats (0,0),(1,0),(0,1),(1,1) with matching data; out_last only on (1,1); first out_valid 3 cycles after the order=7 write.
- 32x32 TU: 64 writes back-to-back, out_ready=1 -> 64 consecutive out_valid cycles in raster order; bStop stays 0.
- Two 16x16 TUs with out_ready=0 -> bStop rises the cycle after the second TU's order=7 write; a third TU's in_valid is ignored. Raise out_ready -> bStop falls one cycle after the first TU's out_last beat is accepted.
- Backpressure: out_ready toggles 1,0,0,1 during a drain -> no block lost or duplicated; out_data stable while stalled.
- Chroma 4x4 TUs, cIdx=1 then cIdx=2 -> two single-beat outputs with out_cIdx=1 then 2, each with out_last=1.
- arst_n pulse mid-drain of a 16x16 TU -> out_valid=0 and bStop=0 immediately; a subsequent 8x8 TU is output correctly.
